// File: rtl/fixed_accumulator_arbiter.sv
// ---------------------------------------------------------------------------
// fixed_accumulator
//   Accumulates IN_DEPTH signed beats into one OUT_WIDTH sum. The finished sum
//   lands in a two-entry output stage: an output register plus a skid slot.
//   While both entries are occupied, data_in_ready is held low.
//
//   Ports
//     clk, rst          clock, asynchronous active-low reset
//     data_in           signed input beat (IN_WIDTH)
//     data_in_valid     beat valid
//     data_in_ready     beat ready (low while the output stage is full)
//     data_out          finished sum, sign-extended to OUT_WIDTH
//     data_out_valid    sum valid
//     data_out_ready    sum consumed
// ---------------------------------------------------------------------------
module fixed_accumulator #(
  parameter int IN_DEPTH  = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = $clog2(IN_DEPTH) + IN_WIDTH
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [IN_WIDTH-1:0]  data_in,
  input  logic                 data_in_valid,
  output logic                 data_in_ready,
  output logic [OUT_WIDTH-1:0] data_out,
  output logic                 data_out_valid,
  input  logic                 data_out_ready
);

  localparam int CNT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(IN_DEPTH - 1);

  logic [CNT_W-1:0]     beatCnt_q, beatCnt_d;
  logic [OUT_WIDTH-1:0] sum_q, sum_d;
  logic [OUT_WIDTH-1:0] slot0_q, slot0_d;
  logic [OUT_WIDTH-1:0] slot1_q, slot1_d;
  logic [1:0]           outCnt_q, outCnt_d;
  logic [OUT_WIDTH-1:0] beatExt;
  logic [OUT_WIDTH-1:0] sumNext;
  logic                 inFire;
  logic                 push;
  logic                 pop;

  assign beatExt        = OUT_WIDTH'($signed(data_in));
  assign data_in_ready  = (outCnt_q != 2'd2);
  assign inFire         = data_in_valid && data_in_ready;
  assign push           = inFire && (beatCnt_q == LAST_BEAT);
  assign data_out       = slot0_q;
  assign data_out_valid = (outCnt_q != 2'd0);
  assign pop            = data_out_valid && data_out_ready;

  // The first beat of a window starts from zero rather than the stale sum.
  assign sumNext = ((beatCnt_q == '0) ? '0 : sum_q) + beatExt;

  always_comb begin
    beatCnt_d = beatCnt_q;
    sum_d     = sum_q;
    slot0_d   = slot0_q;
    slot1_d   = slot1_q;
    outCnt_d  = outCnt_q;

    if (inFire) begin
      if (beatCnt_q == LAST_BEAT) begin
        beatCnt_d = '0;
      end else begin
        beatCnt_d = beatCnt_q + 1'b1;
        sum_d     = sumNext;
      end
    end

    // slot0 is always the head; slot1 only holds a result while slot0 is stalled.
    case ({push, pop})
      2'b10: begin
        if (outCnt_q == 2'd0) begin
          slot0_d = sumNext;
        end else begin
          slot1_d = sumNext;
        end
        outCnt_d = outCnt_q + 2'd1;
      end
      2'b01: begin
        slot0_d  = slot1_q;
        outCnt_d = outCnt_q - 2'd1;
      end
      2'b11: begin
        if (outCnt_q == 2'd1) begin
          slot0_d = sumNext;
        end else begin
          slot0_d = slot1_q;
          slot1_d = sumNext;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      beatCnt_q <= '0;
      sum_q     <= '0;
      slot0_q   <= '0;
      slot1_q   <= '0;
      outCnt_q  <= 2'd0;
    end else begin
      beatCnt_q <= beatCnt_d;
      sum_q     <= sum_d;
      slot0_q   <= slot0_d;
      slot1_q   <= slot1_d;
      outCnt_q  <= outCnt_d;
    end
  end

endmodule

// ---------------------------------------------------------------------------
// fixed_accumulator_arbiter
//   Shares one fixed_accumulator among NUM_REQ streams. A requester owns the
//   accumulator for a whole IN_DEPTH-beat window, so each sum comes from one
//   stream. Each granted requester ID is queued in a tag FIFO, and that FIFO
//   labels the sums as they come back.
//
//   Ports
//     clk, rst              clock, asynchronous active-low reset
//     req_data              packed beats, requester i at [i*IN_WIDTH +: IN_WIDTH]
//     req_data_valid/ready  per-requester handshake
//     acc_data_in*          beat stream to the accumulator
//     acc_data_out*         sum stream from the accumulator
//     data_out, data_out_id tagged sum and its requester
//     data_out_valid/ready  downstream handshake
// ---------------------------------------------------------------------------
module fixed_accumulator_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int IN_DEPTH  = 4,
  parameter int IN_WIDTH  = 32,
  parameter int OUT_WIDTH = $clog2(IN_DEPTH) + IN_WIDTH,
  parameter int ID_WIDTH  = $clog2(NUM_REQ),
  parameter int TAG_DEPTH = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*IN_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]          req_data_valid,
  output logic [NUM_REQ-1:0]          req_data_ready,
  output logic [IN_WIDTH-1:0]         acc_data_in,
  output logic                        acc_data_in_valid,
  input  logic                        acc_data_in_ready,
  input  logic [OUT_WIDTH-1:0]        acc_data_out,
  input  logic                        acc_data_out_valid,
  output logic                        acc_data_out_ready,
  output logic [OUT_WIDTH-1:0]        data_out,
  output logic [ID_WIDTH-1:0]         data_out_id,
  output logic                        data_out_valid,
  input  logic                        data_out_ready
);

  localparam int BEAT_W = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int PTR_W  = $clog2(TAG_DEPTH);
  localparam int TCNT_W = $clog2(TAG_DEPTH + 1);

  localparam logic [BEAT_W-1:0]   LAST_BEAT = BEAT_W'(IN_DEPTH - 1);
  localparam logic [ID_WIDTH-1:0] LAST_REQ  = ID_WIDTH'(NUM_REQ - 1);
  localparam logic [PTR_W-1:0]    LAST_PTR  = PTR_W'(TAG_DEPTH - 1);
  localparam logic [TCNT_W-1:0]   FULL_CNT  = TCNT_W'(TAG_DEPTH);

  typedef enum logic {
    IDLE,
    BURST
  } state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] grant_q, grant_d;
  logic [ID_WIDTH-1:0] lastGrant_q, lastGrant_d;
  logic [BEAT_W-1:0]   beatCnt_q, beatCnt_d;

  logic [ID_WIDTH-1:0] rrPick;
  logic [ID_WIDTH-1:0] rrCand;
  logic                rrFound;
  logic                beatFire;

  logic [ID_WIDTH-1:0] tagMem_q [TAG_DEPTH];
  logic [PTR_W-1:0]    wrPtr_q;
  logic [PTR_W-1:0]    rdPtr_q;
  logic [TCNT_W-1:0]   tagCnt_q;
  logic                tagPush;
  logic                tagPop;
  logic                tagEmpty;
  logic                tagFull;

  assign tagEmpty = (tagCnt_q == '0);
  assign tagFull  = (tagCnt_q == FULL_CNT);

  // Round-robin search starting just after the last completed window's owner.
  always_comb begin
    rrFound = 1'b0;
    rrPick  = lastGrant_q;
    rrCand  = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      rrCand = ID_WIDTH'((int'(lastGrant_q) + k) % NUM_REQ);
      if (!rrFound && req_data_valid[rrCand]) begin
        rrFound = 1'b1;
        rrPick  = rrCand;
      end
    end
  end

  // The grant is only released after the last beat of a window, so a
  // requester that pauses mid-window keeps the accumulator to itself.
  always_comb begin
    state_d           = state_q;
    grant_d           = grant_q;
    lastGrant_d       = lastGrant_q;
    beatCnt_d         = beatCnt_q;
    tagPush           = 1'b0;
    beatFire          = 1'b0;
    req_data_ready    = '0;
    acc_data_in_valid = 1'b0;

    case (state_q)
      IDLE: begin
        // tagFull is the registered count; a pop this cycle does not help.
        if (rrFound && !tagFull) begin
          grant_d = rrPick;
          tagPush = 1'b1;
          state_d = BURST;
        end
      end
      BURST: begin
        acc_data_in_valid       = req_data_valid[grant_q];
        req_data_ready[grant_q] = acc_data_in_ready;
        beatFire                = req_data_valid[grant_q] && acc_data_in_ready;
        if (beatFire) begin
          if (beatCnt_q == LAST_BEAT) begin
            beatCnt_d   = '0;
            lastGrant_d = grant_q;
            state_d     = IDLE;
          end else begin
            beatCnt_d = beatCnt_q + 1'b1;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign acc_data_in = req_data[int'(grant_q) * IN_WIDTH +: IN_WIDTH];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= IDLE;
      grant_q     <= '0;
      lastGrant_q <= LAST_REQ;
      beatCnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      grant_q     <= grant_d;
      lastGrant_q <= lastGrant_d;
      beatCnt_q   <= beatCnt_d;
    end
  end

  // The head of the tag FIFO is always the oldest window whose sum has not
  // yet left, so it labels whatever the accumulator presents next.
  assign data_out           = acc_data_out;
  assign data_out_valid     = acc_data_out_valid && !tagEmpty;
  assign acc_data_out_ready = data_out_ready && !tagEmpty;
  assign data_out_id        = tagEmpty ? '0 : tagMem_q[rdPtr_q];
  assign tagPop             = data_out_valid && data_out_ready;

  always_ff @(posedge clk) begin
    if (tagPush) begin
      tagMem_q[wrPtr_q] <= grant_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wrPtr_q  <= '0;
      rdPtr_q  <= '0;
      tagCnt_q <= '0;
    end else begin
      if (tagPush) begin
        wrPtr_q <= (wrPtr_q == LAST_PTR) ? '0 : wrPtr_q + 1'b1;
      end
      if (tagPop) begin
        rdPtr_q <= (rdPtr_q == LAST_PTR) ? '0 : rdPtr_q + 1'b1;
      end
      case ({tagPush, tagPop})
        2'b10:   tagCnt_q <= tagCnt_q + 1'b1;
        2'b01:   tagCnt_q <= tagCnt_q - 1'b1;
        default: ;
      endcase
    end
  end

  // A sum with no window tag means the accumulator and arbiter lost sync.
  assert property (@(posedge clk) disable iff (!rst) !(acc_data_out_valid && tagEmpty));

endmodule

// File: tb/tb_fixed_accumulator_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fixed_accumulator_arbiter
//   Arbiter wired to a fixed_accumulator, with producers fed from per-requester
//   beat queues. Expected sums, IDs and cycle positions are hand-computed.
// ---------------------------------------------------------------------------
module tb_fixed_accumulator_arbiter;

  localparam int NR   = 4;
  localparam int DEP  = 4;
  localparam int IW   = 8;
  localparam int OW   = 10;
  localparam int IDW  = 2;
  localparam int TAGD = 4;

  logic           clk = 1'b0;
  logic           rst;
  logic [NR*IW-1:0] req_data;
  logic [NR-1:0]  req_data_valid;
  logic [NR-1:0]  req_data_ready;
  logic [IW-1:0]  accIn;
  logic           accInValid;
  logic           accInReady;
  logic [OW-1:0]  accOut;
  logic           accOutValid;
  logic           accOutReady;
  logic [OW-1:0]  data_out;
  logic [IDW-1:0] data_out_id;
  logic           data_out_valid;
  logic           data_out_ready;

  always #5 clk = ~clk;

  fixed_accumulator_arbiter #(
    .NUM_REQ(NR), .IN_DEPTH(DEP), .IN_WIDTH(IW), .OUT_WIDTH(OW),
    .ID_WIDTH(IDW), .TAG_DEPTH(TAGD)
  ) dut (
    .clk(clk), .rst(rst),
    .req_data(req_data), .req_data_valid(req_data_valid), .req_data_ready(req_data_ready),
    .acc_data_in(accIn), .acc_data_in_valid(accInValid), .acc_data_in_ready(accInReady),
    .acc_data_out(accOut), .acc_data_out_valid(accOutValid), .acc_data_out_ready(accOutReady),
    .data_out(data_out), .data_out_id(data_out_id),
    .data_out_valid(data_out_valid), .data_out_ready(data_out_ready)
  );

  fixed_accumulator #(.IN_DEPTH(DEP), .IN_WIDTH(IW), .OUT_WIDTH(OW)) acc (
    .clk(clk), .rst(rst),
    .data_in(accIn), .data_in_valid(accInValid), .data_in_ready(accInReady),
    .data_out(accOut), .data_out_valid(accOutValid), .data_out_ready(accOutReady)
  );

  typedef logic [IW-1:0] beatQ_t [$];
  beatQ_t         srcQ [NR];
  logic [NR-1:0]  holdMask;
  logic           outReadyCfg;

  int             beatLog [$];
  logic [OW-1:0]  gotData [$];
  logic [IDW-1:0] gotId [$];
  int             gotStep [$];
  int             firstFire [NR];
  int             lastFire [NR];
  int             maxReadies;
  int             validCycles;
  int             stepCount;
  int             errors = 0;
  int             checks = 0;

  task automatic clear_logs();
    beatLog.delete();
    gotData.delete();
    gotId.delete();
    gotStep.delete();
    for (int i = 0; i < NR; i++) begin
      firstFire[i] = -1;
      lastFire[i]  = -1;
    end
    maxReadies  = 0;
    validCycles = 0;
    stepCount   = 0;
  endtask

  // One cycle: drive producers at the falling edge, then log the handshakes
  // that the next rising edge will complete.
  task automatic step();
    logic [NR-1:0]    vld;
    logic [NR*IW-1:0] dat;
    @(negedge clk);
    vld = '0;
    dat = '0;
    for (int i = 0; i < NR; i++) begin
      vld[i] = (srcQ[i].size() > 0) && !holdMask[i];
      if (vld[i]) dat[i*IW +: IW] = srcQ[i][0];
    end
    req_data_valid = vld;
    req_data       = dat;
    data_out_ready = outReadyCfg;
    #1;
    if ($countones(req_data_ready) > maxReadies) maxReadies = $countones(req_data_ready);
    for (int i = 0; i < NR; i++) begin
      if (req_data_valid[i] && req_data_ready[i]) begin
        void'(srcQ[i].pop_front());
        beatLog.push_back(i);
        if (firstFire[i] < 0) firstFire[i] = stepCount;
        lastFire[i] = stepCount;
      end
    end
    if (data_out_valid) validCycles++;
    if (data_out_valid && data_out_ready) begin
      gotData.push_back(data_out);
      gotId.push_back(data_out_id);
      gotStep.push_back(stepCount);
    end
    stepCount++;
  endtask

  task automatic reset_dut();
    @(negedge clk);
    rst            = 1'b0;
    req_data_valid = '0;
    req_data       = '0;
    holdMask       = '0;
    outReadyCfg    = 1'b1;
    data_out_ready = 1'b1;
    for (int i = 0; i < NR; i++) srcQ[i].delete();
    repeat (2) @(negedge clk);
    rst = 1'b1;
    clear_logs();
  endtask

  task automatic test_reset();
    rst            = 1'b0;
    req_data_valid = '1;
    req_data       = '1;
    holdMask       = '0;
    outReadyCfg    = 1'b1;
    data_out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    checks++;
    if (req_data_ready !== 4'b0000) begin
      errors++; $display("[TB] FAIL reset_ready: got %b expected 0000", req_data_ready);
    end
    checks++;
    if (accInValid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_acc_in_valid: got %b expected 0", accInValid);
    end
    checks++;
    if (accOutReady !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_acc_out_ready: got %b expected 0", accOutReady);
    end
    checks++;
    if (data_out_valid !== 1'b0 || data_out_id !== 2'd0) begin
      errors++; $display("[TB] FAIL reset_out: got valid=%b id=%0d expected 0/0", data_out_valid, data_out_id);
    end
    req_data_valid = '0;
    rst = 1'b1;
    clear_logs();
    for (int i = 0; i < NR; i++) srcQ[i].push_back(8'd1);
    step();
    checks++;
    if (req_data_ready !== 4'b0000) begin
      errors++; $display("[TB] FAIL idle_bubble: got %b expected 0000", req_data_ready);
    end
  endtask

  task automatic test_single();
    reset_dut();
    srcQ[0] = '{8'd1, 8'd2, 8'd3, 8'd4};
    for (int c = 0; c < 12; c++) step();
    checks++;
    if (gotData.size() != 1 || validCycles != 1) begin
      errors++; $display("[TB] FAIL single_count: got %0d results %0d valid cycles expected 1/1", gotData.size(), validCycles);
    end
    checks++;
    if (gotData.size() < 1 || gotData[0] !== 10'd10 || gotId[0] !== 2'd0) begin
      errors++; $display("[TB] FAIL single_sum: got %0d id %0d expected 10 id 0", gotData.size() > 0 ? gotData[0] : '0, gotId.size() > 0 ? gotId[0] : '0);
    end
    checks++;
    if (firstFire[0] != 1 || gotStep.size() < 1 || gotStep[0] != 5) begin
      errors++; $display("[TB] FAIL single_latency: got first beat %0d result %0d expected 1/5", firstFire[0], gotStep.size() > 0 ? gotStep[0] : -1);
    end
  endtask

  task automatic test_round_robin();
    logic [OW-1:0] expD;
    reset_dut();
    for (int i = 0; i < NR; i++)
      for (int b = 0; b < 2*DEP; b++) srcQ[i].push_back(IW'(i + 1));
    for (int c = 0; c < 80 && gotData.size() < 8; c++) step();
    checks++;
    if (gotData.size() != 8) begin
      errors++; $display("[TB] FAIL rr_count: got %0d expected 8", gotData.size());
    end
    for (int k = 0; k < 8; k++) begin
      expD = OW'(4 * ((k % 4) + 1));
      checks++;
      if (k >= gotData.size() || gotData[k] !== expD || gotId[k] !== IDW'(k % 4)) begin
        errors++; $display("[TB] FAIL rr_result%0d: got %0d id %0d expected %0d id %0d", k, k < gotData.size() ? gotData[k] : '0, k < gotId.size() ? gotId[k] : '0, expD, k % 4);
      end
      checks++;
      if (4*k >= beatLog.size() || beatLog[4*k] != k % 4) begin
        errors++; $display("[TB] FAIL rr_grant%0d: got %0d expected %0d", k, 4*k < beatLog.size() ? beatLog[4*k] : -1, k % 4);
      end
    end
    checks++;
    if (maxReadies > 1) begin
      errors++; $display("[TB] FAIL rr_onehot: got %0d readies expected <=1", maxReadies);
    end
    checks++;
    if (lastFire[3] != 39) begin
      errors++; $display("[TB] FAIL rr_bubble: got last beat step %0d expected 39", lastFire[3]);
    end
  endtask

  task automatic test_hold();
    reset_dut();
    srcQ[2] = '{8'd10, 8'd20, 8'd30, 8'd40};
    repeat (3) step();
    holdMask = 4'b0100;
    srcQ[1]  = '{8'd1, 8'd1, 8'd1, 8'd1};
    for (int c = 0; c < 3; c++) begin
      step();
      checks++;
      if (req_data_ready !== 4'b0100) begin
        errors++; $display("[TB] FAIL hold_grant%0d: got %b expected 0100", c, req_data_ready);
      end
    end
    holdMask = '0;
    for (int c = 0; c < 30 && gotData.size() < 2; c++) step();
    checks++;
    if (firstFire[1] <= lastFire[2]) begin
      errors++; $display("[TB] FAIL hold_order: got req1 first %0d req2 last %0d expected req1 later", firstFire[1], lastFire[2]);
    end
    checks++;
    if (gotData.size() != 2 || gotData[0] !== 10'd100 || gotId[0] !== 2'd2 ||
        gotData[1] !== 10'd4 || gotId[1] !== 2'd1) begin
      errors++; $display("[TB] FAIL hold_results: got %0d results first %0d id %0d expected 100 id 2 then 4 id 1", gotData.size(), gotData.size() > 0 ? gotData[0] : '0, gotId.size() > 0 ? gotId[0] : '0);
    end
  endtask

  task automatic test_backpressure();
    int granted;
    logic [OW-1:0] expD;
    reset_dut();
    outReadyCfg = 1'b0;
    for (int i = 0; i < NR; i++)
      for (int b = 0; b < DEP; b++) srcQ[i].push_back(IW'(i + 1));
    repeat (30) step();
    granted = 0;
    for (int i = 0; i < NR; i++) if (firstFire[i] >= 0) granted++;
    checks++;
    if (req_data_ready !== 4'b0000) begin
      errors++; $display("[TB] FAIL bp_stall: got %b expected 0000", req_data_ready);
    end
    checks++;
    if (granted < 1 || granted > TAGD) begin
      errors++; $display("[TB] FAIL bp_grants: got %0d expected 1..%0d", granted, TAGD);
    end
    checks++;
    if (data_out_valid !== 1'b1 || data_out !== 10'd4 || data_out_id !== 2'd0 || gotData.size() != 0) begin
      errors++; $display("[TB] FAIL bp_head: got valid=%b data=%0d id=%0d expected 1/4/0", data_out_valid, data_out, data_out_id);
    end
    outReadyCfg = 1'b1;
    for (int c = 0; c < 80 && gotData.size() < 4; c++) step();
    checks++;
    if (gotData.size() != 4) begin
      errors++; $display("[TB] FAIL bp_drain_count: got %0d expected 4", gotData.size());
    end
    for (int k = 0; k < 4; k++) begin
      expD = OW'(4 * (k + 1));
      checks++;
      if (k >= gotData.size() || gotData[k] !== expD || gotId[k] !== IDW'(k)) begin
        errors++; $display("[TB] FAIL bp_drain%0d: got %0d id %0d expected %0d id %0d", k, k < gotData.size() ? gotData[k] : '0, k < gotId.size() ? gotId[k] : '0, expD, k);
      end
    end
  endtask

  task automatic test_negative();
    reset_dut();
    srcQ[3] = '{8'hFF, 8'hFE, 8'hFD, 8'hFC};
    for (int c = 0; c < 20 && gotData.size() < 1; c++) step();
    checks++;
    if (gotData.size() != 1 || gotData[0] !== 10'h3F6 || gotId[0] !== 2'd3) begin
      errors++; $display("[TB] FAIL neg_sum: got %0d results first %h id %0d expected 3f6 id 3", gotData.size(), gotData.size() > 0 ? gotData[0] : '0, gotId.size() > 0 ? gotId[0] : '0);
    end
  endtask

  task automatic test_async_reset();
    reset_dut();
    srcQ[1] = '{8'd1, 8'd1, 8'd1, 8'd1};
    for (int c = 0; c < 20 && gotData.size() < 1; c++) step();
    checks++;
    if (gotData.size() != 1 || gotData[0] !== 10'd4 || gotId[0] !== 2'd1) begin
      errors++; $display("[TB] FAIL pre_reset_sum: got %0d results expected one sum 4 id 1", gotData.size());
    end
    srcQ[2] = '{8'd50, 8'd50, 8'd50, 8'd50};
    repeat (3) step();
    @(posedge clk);
    #2;
    checks++;
    if (srcQ[2].size() != 2 || req_data_ready !== 4'b0100) begin
      errors++; $display("[TB] FAIL mid_burst: got %0d left ready %b expected 2 left ready 0100", srcQ[2].size(), req_data_ready);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (req_data_ready !== 4'b0000 || accInValid !== 1'b0 || accOutReady !== 1'b0 ||
        data_out_valid !== 1'b0 || data_out_id !== 2'd0) begin
      errors++; $display("[TB] FAIL async_reset: got ready=%b in_valid=%b out_ready=%b valid=%b id=%0d expected all 0", req_data_ready, accInValid, accOutReady, data_out_valid, data_out_id);
    end
    reset_dut();
    srcQ[0] = '{8'd1, 8'd2, 8'd3, 8'd4};
    srcQ[2] = '{8'd8, 8'd8, 8'd8, 8'd8};
    for (int c = 0; c < 30 && gotData.size() < 2; c++) step();
    checks++;
    if (beatLog.size() < 1 || beatLog[0] != 0) begin
      errors++; $display("[TB] FAIL post_reset_grant: got %0d expected 0", beatLog.size() > 0 ? beatLog[0] : -1);
    end
    checks++;
    if (gotData.size() != 2 || gotData[0] !== 10'd10 || gotId[0] !== 2'd0 ||
        gotData[1] !== 10'd32 || gotId[1] !== 2'd2) begin
      errors++; $display("[TB] FAIL post_reset_sums: got %0d results second %0d expected 10 id 0 then 32 id 2", gotData.size(), gotData.size() > 1 ? gotData[1] : '0);
    end
  endtask

  initial begin
    clear_logs();
    test_reset();
    test_single();
    test_round_robin();
    test_hold();
    test_backpressure();
    test_negative();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
